// File: rtl/gpu_frame_reader_pkg.sv
// Shared types for the GPU frame reader: FIFO entry layout, FSM states and default geometry.
package gpu_pkg;

  localparam logic [31:0] DEF_FRAME_BASE = 32'h0;
  localparam int          DEF_W_LOG2     = 8;
  localparam int          DEF_H_LOG2     = 8;
  // Largest supported W_LOG2 + H_LOG2; smaller frames zero-extend the index.
  localparam int          IDX_MAX_W      = DEF_W_LOG2 + DEF_H_LOG2;

  typedef struct packed {
    logic [7:0]           enc;
    logic [7:0]           dec;
    logic [IDX_MAX_W-1:0] idx;
  } pix_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/gpu_frame_reader_pix_fifo.sv
// Synchronous FIFO with occupancy count and flush; head is read straight from storage.
// Flush wins over push/pop; a push into a full FIFO is only accepted alongside a pop.
module pix_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_dat,
  input  logic                         pop,
  output T                             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign do_pop   = pop && !flush && (cnt_q != '0);
  assign do_push  = push && !flush && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
  assign head_dat = mem_q[rd_q];
  assign count    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

endmodule

// File: rtl/gpu_frame_reader.sv
// Back-pressured frame reader for the iomemory GPU port; first pixel valid 2 cycles after start.
// Reads issue only while FIFO entries plus the in-flight read stay below FIFO_DEPTH.
module gpu_frame_reader
  import gpu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(DEF_FRAME_BASE),
  parameter int                W_LOG2     = DEF_W_LOG2,
  parameter int                H_LOG2     = DEF_H_LOG2,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] gpu_address,
  input  logic [7:0]        encrypted_gpu,
  input  logic [7:0]        decrypted_gpu,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_enc,
  output logic [7:0]        pix_dec,
  output logic [W_LOG2-1:0] pix_x,
  output logic [H_LOG2-1:0] pix_y,
  output logic              pix_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int               IDX_W    = W_LOG2 + H_LOG2;
  localparam int               CNT_W    = $clog2(FIFO_DEPTH+1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  infl_idx_q, infl_idx_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_vld, pop, issue, head_last;
  pix_entry_t        push_ent, head;

  assign fifo_vld  = (fifo_cnt != '0);
  assign pop       = fifo_vld && pix_ready;
  assign head_last = fifo_vld && (head.idx == IDX_MAX_W'(IDX_LAST));
  // Credit check counts the read still in flight so its data always has a slot.
  assign issue     = (state_q == ST_FETCH) && !abort &&
                     (({1'b0, fifo_cnt} + {{CNT_W{1'b0}}, infl_q}) < DEPTH_C);

  assign push_ent  = '{enc: encrypted_gpu, dec: decrypted_gpu, idx: IDX_MAX_W'(infl_idx_q)};

  pix_fifo #(
    .T     (pix_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .push     (infl_q),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    infl_d     = 1'b0;
    infl_idx_d = infl_idx_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      addr_d  = FRAME_BASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
            idx_d   = '0;
            addr_d  = FRAME_BASE;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            infl_d     = 1'b1;
            infl_idx_d = idx_q;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DRAIN;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              addr_d = FRAME_BASE + ADDR_W'(idx_q + IDX_W'(1));
            end
          end
        end
        ST_DRAIN: begin
          // The last pixel is the final entry, so its handshake ends the frame.
          if (pop && head_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            addr_d  = FRAME_BASE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
      addr_q     <= FRAME_BASE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      infl_q     <= infl_d;
      infl_idx_q <= infl_idx_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
    end
  end

  assign gpu_address = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign pix_valid   = fifo_vld;
  assign pix_last    = head_last;
  assign pix_enc     = fifo_vld ? head.enc : 8'h00;
  assign pix_dec     = fifo_vld ? head.dec : 8'h00;
  assign pix_x       = fifo_vld ? head.idx[W_LOG2-1:0] : '0;
  assign pix_y       = fifo_vld ? head.idx[IDX_W-1:W_LOG2] : '0;

endmodule

// File: tb/tb_gpu_frame_reader.sv
// Directed bench for gpu_frame_reader on a 4x4 frame at base 0x30000 with a registered memory model.
module tb_gpu_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, pix_ready;
  logic [31:0] gpu_address;
  logic [7:0]  encrypted_gpu, decrypted_gpu, pix_enc, pix_dec;
  logic [1:0]  pix_x, pix_y;
  logic        pix_valid, pix_last, busy, frame_done;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [31:0] rec_pix[$];
  int          rec_cyc[$];

  always #5 clk = ~clk;

  gpu_frame_reader #(
    .ADDR_W     (32),
    .FRAME_BASE (32'h30000),
    .W_LOG2     (2),
    .H_LOG2     (2),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .gpu_address   (gpu_address),
    .encrypted_gpu (encrypted_gpu),
    .decrypted_gpu (decrypted_gpu),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_enc       (pix_enc),
    .pix_dec       (pix_dec),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_last      (pix_last),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  // Registered read port: data for the address seen in one cycle appears in the next.
  always @(posedge clk) begin
    encrypted_gpu <= gpu_address[7:0];
    decrypted_gpu <= ~gpu_address[7:0];
    cyc           <= cyc + 1;
  end

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      rec_pix.push_back({7'd0, pix_last, 2'd0, pix_y, 2'd0, pix_x, pix_enc, pix_dec});
      rec_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel i of the 4x4 frame: x=i%4, y=i/4, enc=low address byte (=i), dec=its inverse.
  function automatic logic [31:0] exp_pix(input int i);
    logic [7:0] a;
    a = 8'(i);
    exp_pix = {7'd0, (i == 15), 4'(i / 4), 4'(i % 4), a, ~a};
  endfunction

  task automatic check_frame(input string tag);
    check({tag, "_count"}, rec_pix.size(), 16);
    foreach (rec_pix[i]) check($sformatf("%s_pix%0d", tag, i), rec_pix[i], exp_pix(i));
  endtask

  task automatic clear_rec();
    rec_pix.delete();
    rec_cyc.delete();
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 400) begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pix_ready = 1'b1;
    check({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic wait_pixels(input string tag, input int n);
    int k;
    k = 0;
    while (rec_pix.size() < n && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_reached"}, rec_pix.size(), n);
  endtask

  initial begin
    int d0;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr",  gpu_address, 32'h30000);
    check("rst_valid", pix_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  frame_done, 0);
    check("rst_pix",   {pix_last, pix_y, pix_x, pix_enc, pix_dec}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Full frame with ready high: timing of first pixel, throughput, last and done.
    clear_rec();
    start = 1'b1; pix_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_vld_e0", pix_valid, 0);
    tick();
    check("t1_vld_e1", pix_valid, 0);
    tick();
    check("t1_vld_e2", pix_valid, 1);
    check("t1_xy0", {pix_y, pix_x}, 0);
    wait_done("t1", 0);
    check_frame("t1");
    check("t1_thru", (rec_cyc.size() == 16) ? rec_cyc[15] - rec_cyc[0] : -1, 15);
    check("t1_done_lat", (rec_cyc.size() == 16) ? done_cyc - rec_cyc[15] : -1, 1);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_addr", gpu_address, 32'h30000);

    // Consumer stalled from the start: reads stop once 8 are outstanding.
    clear_rec();
    pix_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("t2_freeze_addr", gpu_address, 32'h30008);
    check("t2_valid", pix_valid, 1);
    check("t2_head", {pix_y, pix_x, pix_enc}, 0);
    repeat (3) tick();
    check("t2_still_frozen", gpu_address, 32'h30008);
    pix_ready = 1'b1;
    wait_done("t2", 0);
    check_frame("t2");

    // Random backpressure: the stream must still be complete and byte-exact.
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3", 1);
    check_frame("t3");

    // Abort with data buffered, then replay from (0,0).
    clear_rec();
    start = 1'b1; pix_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_pixels("t4", 6);
    pix_ready = 1'b0;
    repeat (3) tick();
    check("t4_fifo_busy", pix_valid, 1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid", pix_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_addr", gpu_address, 32'h30000);
    pix_ready = 1'b1;
    repeat (5) tick();
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_stays_idle", pix_valid, 0);
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4r", 0);
    check_frame("t4r");

    // Start mid-frame is ignored; abort beats start in the same cycle.
    clear_rec();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pixels("t5", 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 0);
    repeat (5) tick();
    check_frame("t5");
    check("t5_one_done", done_cnt - d0, 1);
    check("t5_idle", busy, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t5_abort_wins", busy, 0);

    // Asynchronous reset in the middle of fetching.
    clear_rec();
    d0 = done_cnt;
    pix_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t6_pre_valid", pix_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_addr", gpu_address, 32'h30000);
    check("t6_valid", pix_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_pix", {pix_last, pix_y, pix_x, pix_enc, pix_dec}, 0);
    check("t6_done", frame_done, 0);
    tick();
    rst_n = 1'b1; pix_ready = 1'b1;
    repeat (5) tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", pix_valid, 0);
    check("t6_idle_addr", gpu_address, 32'h30000);
    check("t6_no_pix", rec_pix.size(), 0);
    check("t6_no_done", done_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1);
  end

endmodule
